hs_rx_deserializer: RTL and testbench
=====================================

// Module: hs_rx_deserializer
// PURPOSE
//  HS-mode receive front end of the D-PHY receiver; counterpart of the driver's HS serializer.
//  Samples the serial HS lane one bit per clock, hunts for the leader sequence, aligns to bytes,
//  and presents deserialized bytes to the receiver's PPI side as single-cycle strobes.
//  Sits between the HS line receiver/comparator and the RX lane control FSM, which drives hs_en.
// PARAMETERS
//  SYNC_BYTE     8'hB8  leader byte; arrives LSB first, i.e. time order 0,0,0,1,1,1,0,1
//  HUNT_TIMEOUT  64     bits sampled in HUNT without a match before sync_err (range 8..255)
//  CNT_W         16     width of the rx_byte_cnt burst byte counter
// PORTS
//  clock        in   1      bit-rate sampling clock; all logic on posedge
//  reset        in   1      asynchronous, active-low reset
//  hs_en        in   1      HS receive enable from lane FSM (high = HS termination on, burst live)
//  hs_bit       in   1      sampled serial lane bit, valid on every posedge while hs_en=1
//  rx_byte      out  8      last completed byte, LSB = first bit received
//  rx_valid     out  1      1-cycle strobe: rx_byte holds a new byte
//  rx_active    out  1      high while in RECEIVE (byte alignment locked)
//  sync_det     out  1      1-cycle strobe on the edge the leader byte completes
//  sync_err     out  1      1-cycle strobe on HUNT timeout
//  rx_byte_cnt  out  CNT_W  bytes delivered in current burst, saturating
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; shift reg, bit_cnt, hunt_cnt, rx_byte=0; all strobes 0;
//   rx_active=0; rx_byte_cnt=0. Outputs are all registered.
//  Shift: sreg_next = {hs_bit, sreg[7:1]}; sreg updates every edge in HUNT/RECEIVE only.
//  FSM states IDLE, HUNT, RECEIVE, ERROR; hs_en=0 forces IDLE from any state on the next edge
//   (sampled bit ignored, partial byte discarded, no rx_valid), and takes priority over all else.
//  IDLE: sreg=0, bit_cnt=0, hunt_cnt=0. hs_en=1 -> HUNT; rx_byte_cnt cleared on this entry.
//   Bit sampled on the IDLE->HUNT edge is not shifted (first shifted bit is on the next edge).
//  HUNT: each edge shifts hs_bit, hunt_cnt+1.
//   sreg_next==SYNC_BYTE -> RECEIVE, sync_det=1 that cycle, bit_cnt=0. Match wins over timeout
//   on the same edge. Else hunt_cnt reaching HUNT_TIMEOUT -> ERROR, sync_err=1 for one cycle.
//   Leading HS-zero bits of any count < timeout are tolerated; match is exact (no bit errors).
//  RECEIVE: rx_active=1. Each edge shifts hs_bit, bit_cnt increments 0..7, wraps 7->0.
//   Edge with bit_cnt==7: rx_byte<=sreg_next, rx_valid=1 next cycle (same edge registers both),
//   rx_byte_cnt+1 saturating at 2^CNT_W-1. Back-to-back bytes -> rx_valid every 8th cycle.
//   No in-burst sync re-hunt; trailer/EoT bits are delivered as data, stripped upstream.
//  ERROR: holds, no shifting, no strobes, until hs_en=0 -> IDLE.
//  rx_byte holds its value between strobes; cleared only by reset. rx_byte_cnt holds after burst
//   end until next IDLE->HUNT.
//  Latency: last bit of byte sampled at edge N -> rx_valid/rx_byte visible after edge N.
// TESTING
//  T1 reset: drive mid-RECEIVE, pulse reset low between edges -> all outputs 0 immediately, IDLE.
//  T2 burst: hs_en=1, 10 zeros, 0xB8 LSB-first, 0x5A, 0xC3 -> sync_det on 18th shifted bit edge,
//   rx_valid at +8 (0x5A) and +16 (0xC3), rx_byte_cnt=2, rx_active=1 through burst.
//  T3 timeout: hs_en=1, 64 zeros -> sync_err single pulse after 64th shifted bit, no rx_valid,
//   stays ERROR with hs_en=1; hs_en=0 -> IDLE next edge.
//  T4 abort: after sync, 3 bits of a byte then hs_en=0 -> no rx_valid, rx_active=0 next edge,
//   rx_byte keeps previous value.
//  T5 match vs timeout: HUNT_TIMEOUT=16, leader completes on exactly the 16th shifted bit ->
//   sync_det=1, sync_err=0, state RECEIVE.
//  T6 saturation: CNT_W=4, burst of 17 bytes -> rx_byte_cnt stops at 15, rx_valid still 17 times;
//   second burst after hs_en low 1 cycle -> counter restarts at 0, sync re-hunted.

Source files
------------

// File: rtl/hs_rx_deserializer.sv
// HS-mode receive deserializer: hunts for the leader byte on the serial lane, locks byte
// alignment and delivers LSB-first bytes as single-cycle strobes with a saturating burst count.
module hs_rx_deserializer #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned HUNT_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_hs_en,
  input  logic             i_hs_bit,
  output logic [7:0]       o_rx_byte,
  output logic             o_rx_valid,
  output logic             o_rx_active,
  output logic             o_sync_det,
  output logic             o_sync_err,
  output logic [CNT_W-1:0] o_rx_byte_cnt
);

  localparam int unsigned HUNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HUNT    = 2'd1,
    S_RECEIVE = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t              r_state;
  logic [7:0]          r_sreg;
  logic [2:0]          r_bit_cnt;
  logic [HUNT_W-1:0]   r_hunt_cnt;
  logic [7:0]          r_rx_byte;
  logic                r_rx_valid;
  logic                r_rx_active;
  logic                r_sync_det;
  logic                r_sync_err;
  logic [CNT_W-1:0]    r_byte_cnt;

  state_t              w_state_nxt;
  logic [7:0]          w_sreg_nxt;
  logic [2:0]          w_bit_cnt_nxt;
  logic [HUNT_W-1:0]   w_hunt_cnt_nxt;
  logic [7:0]          w_rx_byte_nxt;
  logic                w_rx_valid_nxt;
  logic                w_sync_det_nxt;
  logic                w_sync_err_nxt;
  logic [CNT_W-1:0]    w_byte_cnt_nxt;
  logic [7:0]          w_shift;
  logic [HUNT_W:0]     w_hunt_inc;

  assign w_shift    = {i_hs_bit, r_sreg[7:1]};
  assign w_hunt_inc = (HUNT_W+1)'(r_hunt_cnt) + (HUNT_W+1)'(1);

  // Next-state and next-output logic; dropping hs_en overrides every state
  always_comb begin
    w_state_nxt    = r_state;
    w_sreg_nxt     = r_sreg;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_hunt_cnt_nxt = r_hunt_cnt;
    w_rx_byte_nxt  = r_rx_byte;
    w_rx_valid_nxt = 1'b0;
    w_sync_det_nxt = 1'b0;
    w_sync_err_nxt = 1'b0;
    w_byte_cnt_nxt = r_byte_cnt;

    if (!i_hs_en) begin
      w_state_nxt    = S_IDLE;
      w_sreg_nxt     = 8'd0;
      w_bit_cnt_nxt  = 3'd0;
      w_hunt_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_HUNT;
          w_sreg_nxt     = 8'd0;
          w_bit_cnt_nxt  = 3'd0;
          w_hunt_cnt_nxt = '0;
          w_byte_cnt_nxt = '0;
        end
        S_HUNT: begin
          w_sreg_nxt     = w_shift;
          w_hunt_cnt_nxt = HUNT_W'(w_hunt_inc);
          if (w_shift == SYNC_BYTE) begin
            w_state_nxt    = S_RECEIVE;
            w_sync_det_nxt = 1'b1;
            w_bit_cnt_nxt  = 3'd0;
          end else if (w_hunt_inc == (HUNT_W+1)'(HUNT_TIMEOUT)) begin
            w_state_nxt    = S_ERROR;
            w_sync_err_nxt = 1'b1;
          end
        end
        S_RECEIVE: begin
          w_sreg_nxt    = w_shift;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_rx_byte_nxt  = w_shift;
            w_rx_valid_nxt = 1'b1;
            if (r_byte_cnt != {CNT_W{1'b1}}) w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_ERROR;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_sreg      <= 8'd0;
      r_bit_cnt   <= 3'd0;
      r_hunt_cnt  <= '0;
      r_rx_byte   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_rx_active <= 1'b0;
      r_sync_det  <= 1'b0;
      r_sync_err  <= 1'b0;
      r_byte_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sreg      <= w_sreg_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_hunt_cnt  <= w_hunt_cnt_nxt;
      r_rx_byte   <= w_rx_byte_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_rx_active <= (w_state_nxt == S_RECEIVE);
      r_sync_det  <= w_sync_det_nxt;
      r_sync_err  <= w_sync_err_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
    end
  end

  assign o_rx_byte     = r_rx_byte;
  assign o_rx_valid    = r_rx_valid;
  assign o_rx_active   = r_rx_active;
  assign o_sync_det    = r_sync_det;
  assign o_sync_err    = r_sync_err;
  assign o_rx_byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_hs_rx_deserializer.sv
// Directed bench for hs_rx_deserializer: default instance for burst/abort/timeout/reset,
// a small instance (timeout 16, 4-bit counter) for match-vs-timeout and counter saturation.
module tb_hs_rx_deserializer;

  typedef struct packed {
    logic [7:0] tord;     // bits in time order, MSB sent first
    logic [7:0] exp_byte; // hand-computed LSB-first byte
  } vec_t;

  localparam logic [7:0] LEAD_TORD = 8'h1D; // 0xB8 in time order 0,0,0,1,1,1,0,1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en_a, bit_a, en_b, bit_b;
  logic sel;

  logic [7:0]  byte_a, byte_b;
  logic        valid_a, valid_b, active_a, active_b, sdet_a, sdet_b, serr_a, serr_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  hs_rx_deserializer u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_hs_en(en_a), .i_hs_bit(bit_a),
    .o_rx_byte(byte_a), .o_rx_valid(valid_a), .o_rx_active(active_a),
    .o_sync_det(sdet_a), .o_sync_err(serr_a), .o_rx_byte_cnt(cnt_a)
  );

  hs_rx_deserializer #(.SYNC_BYTE(8'hB8), .HUNT_TIMEOUT(16), .CNT_W(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_hs_en(en_b), .i_hs_bit(bit_b),
    .o_rx_byte(byte_b), .o_rx_valid(valid_b), .o_rx_active(active_b),
    .o_sync_det(sdet_b), .o_sync_err(serr_b), .o_rx_byte_cnt(cnt_b)
  );

  logic [7:0]  o_byte;
  logic        o_valid, o_active, o_sdet, o_serr;
  logic [15:0] o_cnt;
  assign o_byte   = sel ? byte_b   : byte_a;
  assign o_valid  = sel ? valid_b  : valid_a;
  assign o_active = sel ? active_b : active_a;
  assign o_sdet   = sel ? sdet_b   : sdet_a;
  assign o_serr   = sel ? serr_b   : serr_a;
  assign o_cnt    = sel ? 16'(cnt_b) : cnt_a;

  int total = 0;
  int bad   = 0;
  logic [7:0] prev_byte;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic v, input logic a, input logic d,
                           input logic e);
    chk({tag, ".rx_valid"},  32'(o_valid),  32'(v));
    chk({tag, ".rx_active"}, 32'(o_active), 32'(a));
    chk({tag, ".sync_det"},  32'(o_sdet),   32'(d));
    chk({tag, ".sync_err"},  32'(o_serr),   32'(e));
  endtask

  task automatic step(input logic en, input logic b);
    if (sel) begin en_b = en; bit_b = b; end
    else     begin en_a = en; bit_a = b; end
    @(posedge clk);
    #1;
  endtask

  // Leader preceded by nzeros HS-zero bits; sync_det only on the final leader bit
  task automatic hunt_leader(input string tag, input int nzeros);
    for (int i = 0; i < nzeros; i++) begin
      step(1'b1, 1'b0);
      chk_flags({tag, ".zero"}, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, LEAD_TORD[7-k]);
      if (k < 7) chk_flags({tag, ".lead"}, 1'b0, 1'b0, 1'b0, 1'b0);
      else       chk_flags({tag, ".sync"}, 1'b0, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic send_byte(input string tag, input logic [7:0] tord, input logic [7:0] exp_byte,
                           input logic [15:0] exp_cnt);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, tord[7-k]);
      if (k < 7) begin
        chk_flags({tag, ".mid"}, 1'b0, 1'b1, 1'b0, 1'b0);
        chk({tag, ".hold_byte"}, 32'(o_byte), 32'(prev_byte));
      end else begin
        chk_flags({tag, ".end"}, 1'b1, 1'b1, 1'b0, 1'b0);
        chk({tag, ".rx_byte"}, 32'(o_byte), 32'(exp_byte));
        chk({tag, ".cnt"},     32'(o_cnt),  32'(exp_cnt));
      end
    end
    prev_byte = exp_byte;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, ".rx_byte"}, 32'(o_byte), 32'h0);
    chk({tag, ".cnt"},     32'(o_cnt),  32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d, t;
    logic [15:0] ec;

    vecs[0] = '{tord: 8'h5A, exp_byte: 8'h5A};
    vecs[1] = '{tord: 8'hC3, exp_byte: 8'hC3};
    vecs[2] = '{tord: 8'h80, exp_byte: 8'h01};
    vecs[3] = '{tord: 8'h48, exp_byte: 8'h12};
    vecs[4] = '{tord: 8'h07, exp_byte: 8'hE0};
    vecs[5] = '{tord: 8'hFF, exp_byte: 8'hFF};
    vecs[6] = '{tord: 8'h1D, exp_byte: 8'hB8};

    sel = 1'b0; rst_n = 1'b0;
    en_a = 1'b0; bit_a = 1'b0; en_b = 1'b0; bit_b = 1'b0;
    prev_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_a");
    rst_n = 1'b1;

    // Burst: 10 zeros, leader, then the byte table
    step(1'b1, 1'b0);
    chk_flags("enter_hunt", 1'b0, 1'b0, 1'b0, 1'b0);
    hunt_leader("burst", 10);
    chk("burst.cnt_at_sync", 32'(o_cnt), 32'h0);
    for (int i = 0; i < 7; i++) send_byte($sformatf("vec%0d", i), vecs[i].tord, vecs[i].exp_byte,
                                          16'(i + 1));

    // Abort after 3 bits: partial byte discarded
    step(1'b1, 1'b1); chk_flags("abort.b0", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0); chk_flags("abort.b1", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1); chk_flags("abort.b2", 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk_flags("abort.drop", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort.rx_byte", 32'(o_byte), 32'hB8);
    chk("abort.cnt", 32'(o_cnt), 32'd7);
    step(1'b0, 1'b0);
    chk("idle.cnt_hold", 32'(o_cnt), 32'd7);

    // Timeout: 64 zeros without a match
    step(1'b1, 1'b0);
    chk("timeout.cnt_clear", 32'(o_cnt), 32'h0);
    for (int i = 1; i <= 64; i++) begin
      step(1'b1, 1'b0);
      if (i < 64) chk($sformatf("timeout.pre%0d", i), 32'(o_serr), 32'h0);
      else        chk_flags("timeout.err", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, LEAD_TORD[7-k]);
      chk_flags("error.hold", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    chk_flags("error.exit", 1'b0, 1'b0, 1'b0, 1'b0);

    // Back through IDLE: immediate leader syncs, then reset mid-byte
    step(1'b1, 1'b0);
    hunt_leader("resync", 0);
    send_byte("pre_reset", 8'h5A, 8'h5A, 16'd1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    #1 rst_n = 1'b1;
    prev_byte = 8'h00;
    step(1'b1, 1'b0);
    chk_all_zero("post_reset_idle");
    hunt_leader("post_reset", 0);
    chk("post_reset.rx_byte", 32'(o_byte), 32'h0);
    step(1'b0, 1'b0);

    // Small instance: leader completes exactly on the 16th shifted bit
    sel = 1'b1;
    prev_byte = 8'h00;
    step(1'b1, 1'b0);
    hunt_leader("match_vs_timeout", 8);

    // 17 bytes into a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      d = 8'(i * 37 + 5);
      for (int k = 0; k < 8; k++) t[7-k] = d[k];
      ec = (i + 1 > 15) ? 16'd15 : 16'(i + 1);
      send_byte($sformatf("sat%0d", i), t, d, ec);
    end
    step(1'b0, 1'b0);
    chk_flags("sat.end", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat.cnt_hold", 32'(o_cnt), 32'd15);
    step(1'b1, 1'b0);
    chk("burst2.cnt_clear", 32'(o_cnt), 32'h0);
    hunt_leader("burst2", 3);
    send_byte("burst2.byte", 8'h48, 8'h12, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
